// File: rtl/seq_detector.sv
// seq_detector: serial bit-pattern detector.
// Takes one bit of `a` on each rising clk edge. Pulses `out` for one cycle whenever the most
// recent PATTERN_WIDTH bits equal PATTERN (MSB = oldest bit). A saturating counter tracks matches.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   a            serial data bit
//   out          registered detect flag, one cycle per match
//   match_count  matches since reset, saturates at all-ones
module seq_detector #(
    parameter int unsigned              PATTERN_WIDTH = 7,
    parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 7'b1001110,
    parameter bit                       OVERLAP       = 1'b1,
    parameter int unsigned              COUNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a,
    output logic                   out,
    output logic [COUNT_WIDTH-1:0] match_count
);

    localparam int unsigned FILL_W = $clog2(PATTERN_WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_WIDTH);

    logic [PATTERN_WIDTH-1:0] history_q, history_d, history_shift;
    logic [FILL_W-1:0]        fill_q, fill_d, fill_inc;
    logic                     match;
    logic [COUNT_WIDTH-1:0]   count_d;

    always_comb begin
        history_shift = {history_q[PATTERN_WIDTH-2:0], a};
        fill_inc      = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        // The fill check blocks false hits from the zeroed history, e.g. an all-zero PATTERN.
        match         = (fill_inc == FILL_FULL) && (history_shift == PATTERN);

        history_d = history_shift;
        fill_d    = fill_inc;
        if (match && !OVERLAP) begin
            // Non-overlapping mode: the next match needs a full set of fresh bits.
            history_d = '0;
            fill_d    = '0;
        end

        count_d = match_count;
        if (match && (match_count != {COUNT_WIDTH{1'b1}})) begin
            count_d = match_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            history_q   <= '0;
            fill_q      <= '0;
            out         <= 1'b0;
            match_count <= '0;
        end else begin
            history_q   <= history_d;
            fill_q      <= fill_d;
            out         <= match;
            match_count <= count_d;
        end
    end

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector. Five instances with different parameters share `a`.
// Each has its own reset; an instance that is not under test is held in reset.
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       a = 1'b0;
    logic [4:0] rst_n = 5'b0;

    logic       out0, out1, out2, out3, out4;
    logic [7:0] cnt0, cnt1, cnt2, cnt4;
    logic [1:0] cnt3;

    // Default: 7-bit 1001110, overlapping.
    seq_detector dut0 (.clk(clk), .rst_n(rst_n[0]), .a(a), .out(out0), .match_count(cnt0));

    seq_detector #(.PATTERN_WIDTH(3), .PATTERN(3'b101), .OVERLAP(1'b1), .COUNT_WIDTH(8)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .a(a), .out(out1), .match_count(cnt1));

    seq_detector #(.PATTERN_WIDTH(3), .PATTERN(3'b101), .OVERLAP(1'b0), .COUNT_WIDTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n[2]), .a(a), .out(out2), .match_count(cnt2));

    seq_detector #(.PATTERN_WIDTH(2), .PATTERN(2'b11), .OVERLAP(1'b1), .COUNT_WIDTH(2)) dut3 (
        .clk(clk), .rst_n(rst_n[3]), .a(a), .out(out3), .match_count(cnt3));

    seq_detector #(.PATTERN_WIDTH(3), .PATTERN(3'b000), .OVERLAP(1'b1), .COUNT_WIDTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n[4]), .a(a), .out(out4), .match_count(cnt4));

    always #7 clk = ~clk;

    typedef struct {
        int         dut;
        int         step;
        logic       exp_out;
        logic [7:0] exp_cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    // Drive one edge's worth of stimulus for instance d and queue the result expected after it.
    task automatic drive(input int d, input logic rst, input logic bit_a,
                         input logic eo, input logic [7:0] ec);
        exp_t e;
        @(negedge clk);
        rst_n    = 5'b0;
        rst_n[d] = rst;
        a        = bit_a;
        step_no++;
        e.dut     = d;
        e.step    = step_no;
        e.exp_out = eo;
        e.exp_cnt = ec;
        sb.push_back(e);
    endtask

    task automatic seq(input int d, input int n, input logic [31:0] bits,
                       input logic [31:0] outs, input logic [7:0] cnts[]);
        // bits/outs are listed MSB first: bit n-1 goes on the first edge.
        for (int i = n - 1; i >= 0; i--) begin
            drive(d, 1'b1, bits[i], outs[i], cnts[n-1-i]);
        end
    endtask

    // Monitor: compare just after every edge for which an expectation was queued.
    exp_t       m;
    logic       got_out;
    logic [7:0] got_cnt;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            m = sb.pop_front();
            case (m.dut)
                0: begin got_out = out0; got_cnt = cnt0; end
                1: begin got_out = out1; got_cnt = cnt1; end
                2: begin got_out = out2; got_cnt = cnt2; end
                3: begin got_out = out3; got_cnt = {6'b0, cnt3}; end
                default: begin got_out = out4; got_cnt = cnt4; end
            endcase
            checks++;
            if (got_out !== m.exp_out) begin
                errors++;
                $display("FAIL out dut%0d step%0d: got %b expected %b",
                         m.dut, m.step, got_out, m.exp_out);
            end
            checks++;
            if (got_cnt !== m.exp_cnt) begin
                errors++;
                $display("FAIL match_count dut%0d step%0d: got %0d expected %0d",
                         m.dut, m.step, got_cnt, m.exp_cnt);
            end
        end
    end

    logic [7:0] z7[] = '{7{8'd0}};

    initial begin
        // 1. Reset held 3 edges with a=1, then 6 ones after release: no pulse.
        for (int i = 0; i < 3; i++) drive(0, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 6; i++) drive(0, 1'b1, 1'b1, 1'b0, 8'd0);

        // 2. Default pattern, then one more 0 clears the pulse.
        drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
        seq(0, 7, 32'b1001110, 32'b0000001, '{0, 0, 0, 0, 0, 0, 1});
        drive(0, 1'b1, 1'b0, 1'b0, 8'd1);

        // 3. Near miss 1001100.
        drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
        seq(0, 7, 32'b1001100, 32'b0, z7);

        // 5. Mid-sequence reset, then 1,0 followed by a full pattern: one pulse at the end.
        drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
        seq(0, 5, 32'b10011, 32'b0, '{0, 0, 0, 0, 0});
        drive(0, 1'b0, 1'b1, 1'b0, 8'd0);
        seq(0, 9, 32'b101001110, 32'b000000001, '{0, 0, 0, 0, 0, 0, 0, 0, 1});

        // Reset on the edge that would complete a match wins.
        drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
        seq(0, 6, 32'b100111, 32'b0, '{0, 0, 0, 0, 0, 0});
        drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(0, 1'b1, 1'b0, 1'b0, 8'd0);

        // 4. PATTERN=101 with and without overlap on 10101.
        drive(1, 1'b0, 1'b0, 1'b0, 8'd0);
        seq(1, 5, 32'b10101, 32'b00101, '{0, 0, 1, 1, 2});
        drive(2, 1'b0, 1'b0, 1'b0, 8'd0);
        seq(2, 5, 32'b10101, 32'b00100, '{0, 0, 1, 1, 1});

        // 6. Saturation: 2-bit counter, pattern 11, six ones then a zero.
        drive(3, 1'b0, 1'b0, 1'b0, 8'd0);
        seq(3, 7, 32'b1111110, 32'b0111110, '{0, 1, 2, 3, 3, 3, 3});

        // All-zero pattern: no hit until three bits have actually arrived.
        drive(4, 1'b0, 1'b0, 1'b0, 8'd0);
        seq(4, 5, 32'b00001, 32'b00110, '{0, 0, 1, 2, 2});

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
